// File: rtl/rc4_pkg.sv
// Shared types and helpers for the ARC4 cracker datapath.
// Holds the printable-range constants and the validator state encoding.
package rc4_pkg;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [2:0] {
        PV_IDLE,
        PV_RD_LEN,
        PV_WAIT_LEN,
        PV_SCAN,
        PV_DONE
    } pv_state_t;

    function automatic logic is_printable(
        input logic [7:0] b,
        input logic [7:0] lo = PRINT_LO,
        input logic [7:0] hi = PRINT_HI
    );
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/pt_validate_if.sv
// Control and pt-memory bundle between the cracker and pt_validate.
// master = cracker/memory side, slave = validator.
interface pt_validate_if #(
    parameter int ADDR_W = 8
) ();

    logic              en;
    logic              rdy;
    logic              valid;
    logic [ADDR_W-1:0] bad_idx;
    logic [ADDR_W-1:0] pt_addr;
    logic [7:0]        pt_rddata;

    modport master (
        output en,
        output pt_rddata,
        input  rdy,
        input  valid,
        input  bad_idx,
        input  pt_addr
    );

    modport slave (
        input  en,
        input  pt_rddata,
        output rdy,
        output valid,
        output bad_idx,
        output pt_addr
    );

endinterface

// File: rtl/pt_validate.sv
// Scans length-prefixed plaintext and reports whether all characters are
// printable, plus the index of the first offending byte.
module pt_validate
    import rc4_pkg::*;
#(
    parameter logic [7:0] LO_CHAR = PRINT_LO,
    parameter logic [7:0] HI_CHAR = PRINT_HI,
    parameter int         ADDR_W  = 8
) (
    input logic          clk,
    input logic          rst_n,
    pt_validate_if.slave bus
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    pv_state_t         state;
    pv_state_t         state_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_n;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] len_n;
    logic [ADDR_W-1:0] bad_q;
    logic [ADDR_W-1:0] bad_n;
    logic              valid_q;
    logic              valid_n;
    logic              ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= PV_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            bad_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            idx_q   <= idx_n;
            len_q   <= len_n;
            bad_q   <= bad_n;
            valid_q <= valid_n;
        end
    end

    // addr_q is the address the memory samples at the end of this cycle,
    // so data for idx_q is on pt_rddata while addr_q = idx_q + 1.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        idx_n   = idx_q;
        len_n   = len_q;
        bad_n   = bad_q;
        valid_n = valid_q;
        ok      = is_printable(bus.pt_rddata, LO_CHAR, HI_CHAR);
        unique case (state)
            PV_IDLE: begin
                if (bus.en) begin
                    state_n = PV_RD_LEN;
                    addr_n  = '0;
                    bad_n   = '0;
                    valid_n = 1'b0;
                end
            end
            PV_RD_LEN: begin
                addr_n  = ONE;
                state_n = PV_WAIT_LEN;
            end
            PV_WAIT_LEN: begin
                len_n = ADDR_W'(bus.pt_rddata);
                idx_n = ONE;
                if (bus.pt_rddata == 8'h00) begin
                    valid_n = 1'b1;
                    state_n = PV_DONE;
                end else begin
                    addr_n  = addr_q + ONE;
                    state_n = PV_SCAN;
                end
            end
            PV_SCAN: begin
                if (!ok) begin
                    bad_n   = idx_q;
                    valid_n = 1'b0;
                    state_n = PV_DONE;
                end else if (idx_q == len_q) begin
                    valid_n = 1'b1;
                    state_n = PV_DONE;
                end else begin
                    idx_n  = idx_q + ONE;
                    addr_n = addr_q + ONE;
                end
            end
            PV_DONE: begin
                state_n = PV_IDLE;
            end
            default: begin
                state_n = PV_IDLE;
            end
        endcase
    end

    assign bus.rdy     = (state == PV_IDLE);
    assign bus.valid   = valid_q;
    assign bus.bad_idx = bad_q;
    assign bus.pt_addr = addr_q;

endmodule

// File: tb/tb_pt_validate.sv
// Randomized scoreboard bench for pt_validate with a behavioural
// plaintext checker and a synchronous-read pt memory model.
module tb_pt_validate;

    typedef struct {
        int v;
        int bad;
        int lat;
        int maxa;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem [0:255];
    exp_t q[$];
    int cyc = 0;
    bit rst_edge = 1'b1;
    int done_cnt = 0;
    int ntotal = 0;
    int nbad = 0;

    pt_validate_if #(.ADDR_W(8)) bus ();

    pt_validate dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.pt_rddata <= mem[bus.pt_addr];

    function automatic exp_t model(input int acc);
        exp_t e;
        int l;
        l = int'(mem[0]);
        e.v = 1;
        e.bad = 0;
        e.acc = acc;
        e.lat = l + 3;
        for (int i = 1; i <= l; i++) begin
            if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
                e.v = 0;
                e.bad = i;
                e.lat = i + 3;
                break;
            end
        end
        // highest address put on the bus: the read one past the last check
        if (l == 0) e.maxa = 1;
        else e.maxa = (e.lat - 2 > 255) ? 255 : e.lat - 2;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_edge <= !rst_n;
        if (!rst_n) q.delete();
        else if (bus.en && bus.rdy) q.push_back(model(cyc + 1));
    end

    task automatic chk(input string n, input int a, input int e);
        ntotal++;
        if (a != e) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    initial begin
        exp_t e;
        int maxa;
        bit prev_rdy;
        maxa = 0;
        prev_rdy = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_edge) begin
                chk("rst_rdy", int'(bus.rdy), 1);
                chk("rst_valid", int'(bus.valid), 0);
                chk("rst_bad_idx", int'(bus.bad_idx), 0);
                chk("rst_pt_addr", int'(bus.pt_addr), 0);
            end else begin
                if (prev_rdy && !bus.rdy) begin
                    chk("clr_valid", int'(bus.valid), 0);
                    chk("clr_bad_idx", int'(bus.bad_idx), 0);
                    maxa = int'(bus.pt_addr);
                end else if (!bus.rdy && int'(bus.pt_addr) > maxa) begin
                    maxa = int'(bus.pt_addr);
                end
                if (!prev_rdy && bus.rdy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("valid", int'(bus.valid), e.v);
                        chk("bad_idx", int'(bus.bad_idx), e.bad);
                        chk("latency", cyc - e.acc, e.lat);
                        chk("max_addr", maxa, e.maxa);
                    end
                    done_cnt++;
                end
            end
            prev_rdy = bus.rdy;
        end
    end

    task automatic load(input logic [7:0] b[$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < b.size(); i++) mem[i] = b[i];
    endtask

    task automatic wait_idle(input int noise);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            bus.en = 1'b0;
            if (q.size() == 0 && bus.rdy) begin
                ok = 1'b1;
                break;
            end
            if (noise != 0 && !bus.rdy && $urandom_range(0, 2) == 0)
                bus.en = 1'b1;
        end
        bus.en = 1'b0;
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic scan(input logic [7:0] b[$], input int noise);
        load(b);
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        wait_idle(noise);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d[$];
        int l;
        int target;
        bit got;
        bus.en = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        d = '{8'h05, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        scan(d, 0);
        d = '{8'h04, 8'h41, 8'h42, 8'h0A, 8'h43};
        scan(d, 0);
        d = '{8'h02, 8'h20, 8'h7E};
        scan(d, 0);
        d = '{8'h01, 8'h7F};
        scan(d, 0);
        d = '{8'h01, 8'h1F};
        scan(d, 0);
        d = '{8'h00};
        scan(d, 0);
        d = '{};
        d.push_back(8'hFF);
        repeat (255) d.push_back(8'h61);
        scan(d, 1);
        d[255] = 8'h80;
        scan(d, 0);

        // abandon an L=40 scan with a one-edge reset at cycle 10
        d = '{};
        d.push_back(8'd40);
        repeat (40) d.push_back(8'h62);
        load(d);
        @(negedge clk);
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        scan(d, 0);

        // en held high: back-to-back restarts from the same plaintext
        d = '{8'h03, 8'h31, 8'h01, 8'h33};
        load(d);
        @(negedge clk);
        target = done_cnt + 2;
        got = 1'b0;
        bus.en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_cnt >= target) begin
                got = 1'b1;
                break;
            end
        end
        bus.en = 1'b0;
        if (!got) chk("held_en_timeout", 0, 1);
        wait_idle(0);

        for (int n = 0; n < 30; n++) begin
            l = $urandom_range(0, 30);
            d = '{};
            d.push_back(8'(l));
            for (int i = 0; i < l; i++) begin
                case ($urandom_range(0, 11))
                    0: d.push_back(8'($urandom_range(0, 31)));
                    1: d.push_back(8'($urandom_range(127, 255)));
                    2: d.push_back(8'h20);
                    3: d.push_back(8'h7E);
                    default: d.push_back(8'($urandom_range(32, 126)));
                endcase
            end
            scan(d, 1);
        end

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", ntotal, nbad);
        $finish;
    end

endmodule
